// File: rtl/conv_window_feeder.sv
// Raster-to-column window feeder: buffers KERNEL_SIZE-1 image rows per channel and
// emits one vertical KERNEL_SIZE-pixel column per accepted pixel once enough rows are held.
module conv_window_feeder #(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 6,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BIT_WIDTH*CHANNEL-1:0]             in_pixel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0] out_column,
  output logic                                     out_win_valid,
  output logic                                     out_last
);

  localparam int PW      = BIT_WIDTH * CHANNEL;
  localparam int COLW    = BIT_WIDTH * KERNEL_SIZE * CHANNEL;
  localparam int CW      = $clog2(IMG_WIDTH);
  localparam int RW      = $clog2(IMG_HEIGHT);
  localparam int LB_ROWS = KERNEL_SIZE - 1;

  typedef enum logic {S_FILL, S_STREAM} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            w_accept, w_col_last, w_row_last;
  logic [PW-1:0]   r_lb [LB_ROWS][IMG_WIDTH];
  logic [PW-1:0]   w_lb_rd [LB_ROWS];
  logic [COLW-1:0] w_column;

  logic            r_out_valid, r_win_valid, r_last;
  logic [COLW-1:0] r_out_column;

  assign in_ready      = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_col_last    = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last    = (r_row == RW'(IMG_HEIGHT - 1));
  assign out_valid     = r_out_valid;
  assign out_column    = r_out_column;
  assign out_win_valid = r_win_valid;
  assign out_last      = r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // Streaming starts once the row that completes the first KERNEL_SIZE-1 rows wraps.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    if (w_accept && w_col_last) begin
      if (w_row_last)                            w_state_next = S_FILL;
      else if (r_row == RW'(KERNEL_SIZE - 2))    w_state_next = S_STREAM;
    end
  end

  // NOTE: line buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= in_pixel;
      for (int j = 1; j < LB_ROWS; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
    end
  end

  always_comb begin
    for (int j = 0; j < LB_ROWS; j++) w_lb_rd[j] = r_lb[j][r_col];
  end

  // Row 0 of each channel is the oldest buffered row; the last row is the live pixel.
  always_comb begin
    w_column = '0;
    for (int ch = 0; ch < CHANNEL; ch++) begin
      for (int r = 0; r < LB_ROWS; r++)
        w_column[(ch*KERNEL_SIZE + r)*BIT_WIDTH +: BIT_WIDTH] =
          w_lb_rd[LB_ROWS-1-r][ch*BIT_WIDTH +: BIT_WIDTH];
      w_column[(ch*KERNEL_SIZE + KERNEL_SIZE-1)*BIT_WIDTH +: BIT_WIDTH] =
        in_pixel[ch*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_column <= '0;
      r_win_valid  <= 1'b0;
      r_last       <= 1'b0;
    end else if (w_accept && r_state == S_STREAM) begin
      r_out_valid  <= 1'b1;
      r_out_column <= w_column;
      r_win_valid  <= (r_col >= CW'(KERNEL_SIZE - 1));
      r_last       <= w_row_last && w_col_last;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder on an 8x6 image, 5-row kernel, 2 channels:
// directed frame/backpressure/reset scenarios plus a randomized scoreboard run.
module tb_conv_window_feeder;

  localparam int BW = 8, K = 5, CH = 2, W = 8, H = 6;
  localparam int PW = BW * CH;
  localparam int COLW = BW * K * CH;
  localparam int FRAME_PIX = W * H;

  typedef struct {
    logic [COLW-1:0] col;
    logic            wv;
    logic            lst;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, out_win_valid, out_last;
  logic [PW-1:0]   in_pixel;
  logic [COLW-1:0] out_column;

  int n_tests = 0;
  int n_fail  = 0;

  conv_window_feeder #(
    .BIT_WIDTH(BW), .KERNEL_SIZE(K), .CHANNEL(CH), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_column(out_column),
    .out_win_valid(out_win_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test pattern: channel 0 = r*16+c, channel 1 = channel 0 + 0x80.
  function automatic logic [PW-1:0] pat(input int r, input int c);
    logic [7:0] p0;
    p0 = 8'(r * 16 + c);
    return {p0 + 8'h80, p0};
  endfunction

  function automatic logic [COLW-1:0] pat_col(input int r, input int c);
    logic [COLW-1:0] col;
    logic [PW-1:0]   px;
    col = '0;
    for (int k = 0; k < K; k++) begin
      px = pat(r - (K - 1) + k, c);
      for (int ch = 0; ch < CH; ch++)
        col[(ch*K + k)*BW +: BW] = px[ch*BW +: BW];
    end
    return col;
  endfunction

  // One cycle: apply inputs at the falling edge, observe 1 time unit later, advance.
  task automatic drive(input logic v, input logic rdy, input logic [PW-1:0] pix,
                       output logic fire, output logic acc, output logic ov,
                       output logic ir, output logic [COLW-1:0] col,
                       output logic wv, output logic lst);
    in_valid  = v;
    out_ready = rdy;
    in_pixel  = pix;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    fire = out_valid && rdy;
    acc  = v && in_ready;
    col  = out_column;
    wv   = out_win_valid;
    lst  = out_last;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    #1;
    n_tests += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (out_column !== '0) begin n_fail++; $display("FAIL rst_out_column: got %h expected 0", out_column); end
    if (out_win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid: got %b expected 0", out_win_valid); end
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b expected 0", out_last); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Streams one full pattern frame from (0,0) with out_ready held high.
  task automatic test_frame(input string tag);
    int r = 0, c = 0, acc_n = 0, beats = 0, wins = 0, early = 0, er, ec;
    logic fire, acc, ov, ir, wv, lst;
    logic [COLW-1:0] col;
    for (int cyc = 0; cyc < 200 && (acc_n < FRAME_PIX || out_valid); cyc++) begin
      drive(acc_n < FRAME_PIX, 1'b1, pat(r, c), fire, acc, ov, ir, col, wv, lst);
      if (acc_n <= (K - 1) * W && ov) early++;
      if (fire) begin
        er = (K - 1) + beats / W;
        ec = beats % W;
        n_tests += 3;
        if (col !== pat_col(er, ec)) begin
          n_fail++; $display("FAIL %s beat(%0d,%0d) column: got %h expected %h", tag, er, ec, col, pat_col(er, ec));
        end
        if (wv !== (ec >= K - 1)) begin
          n_fail++; $display("FAIL %s beat(%0d,%0d) win_valid: got %b expected %b", tag, er, ec, wv, ec >= K - 1);
        end
        if (lst !== (er == H - 1 && ec == W - 1)) begin
          n_fail++; $display("FAIL %s beat(%0d,%0d) last: got %b expected %b", tag, er, ec, lst, er == H - 1 && ec == W - 1);
        end
        if (beats == 0) begin
          n_tests++;
          if (col !== 80'hC0B0A090804030201000) begin
            n_fail++; $display("FAIL %s first_beat: got %h expected C0B0A090804030201000", tag, col);
          end
        end
        if (er == H - 1 && ec == W - 1) begin
          n_tests++;
          if (col !== 80'hD7C7B7A7975747372717) begin
            n_fail++; $display("FAIL %s last_beat: got %h expected D7C7B7A7975747372717", tag, col);
          end
        end
        beats++;
        if (wv) wins++;
      end
      if (acc) begin
        acc_n++;
        c++;
        if (c == W) begin c = 0; r++; end
      end
    end
    n_tests += 4;
    if (early != 0) begin n_fail++; $display("FAIL %s fill_no_valid: got %0d early valid cycles expected 0", tag, early); end
    if (acc_n != FRAME_PIX) begin n_fail++; $display("FAIL %s accepted: got %0d expected %0d", tag, acc_n, FRAME_PIX); end
    if (beats != (H - K + 1) * W) begin n_fail++; $display("FAIL %s beats: got %0d expected %0d", tag, beats, (H - K + 1) * W); end
    if (wins != (H - K + 1) * (W - K + 1)) begin n_fail++; $display("FAIL %s windows: got %0d expected %0d", tag, wins, (H - K + 1) * (W - K + 1)); end
  endtask

  task automatic test_backpressure();
    int r = 0, c = 0, acc_n = 0, beats = 0, stall = 0;
    bit after_stall = 0;
    logic fire, acc, ov, ir, wv, lst, rdy;
    logic [COLW-1:0] col;
    apply_reset();
    for (int cyc = 0; cyc < 200 && (acc_n < FRAME_PIX || out_valid); cyc++) begin
      rdy = !(out_valid && beats == 2 && stall < 3);
      drive(acc_n < FRAME_PIX, rdy, pat(r, c), fire, acc, ov, ir, col, wv, lst);
      if (!rdy) begin
        stall++;
        n_tests += 3;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", ir); end
        if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", ov); end
        if (col !== 80'hC2B2A292824232221202) begin
          n_fail++; $display("FAIL bp_hold_column: got %h expected C2B2A292824232221202", col);
        end
        after_stall = 1;
      end
      if (fire) begin
        n_tests++;
        if (col !== pat_col(K - 1 + beats / W, beats % W)) begin
          n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", beats, col, pat_col(K - 1 + beats / W, beats % W));
        end
        if (after_stall && beats == 3) begin
          n_tests++;
          if (col[4*BW +: BW] !== 8'h43) begin
            n_fail++; $display("FAIL bp_next_beat: got %h expected 43", col[4*BW +: BW]);
          end
        end
        beats++;
      end
      if (acc) begin
        acc_n++;
        c++;
        if (c == W) begin c = 0; r++; end
      end
    end
    n_tests += 3;
    if (stall != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall); end
    if (acc_n != FRAME_PIX) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", acc_n, FRAME_PIX); end
    if (beats != (H - K + 1) * W) begin n_fail++; $display("FAIL bp_beats: got %0d expected %0d", beats, (H - K + 1) * W); end
  endtask

  task automatic test_reset_midframe();
    int r = 0, c = 0, acc_n = 0;
    logic fire, acc, ov, ir, wv, lst;
    logic [COLW-1:0] col;
    apply_reset();
    for (int cyc = 0; cyc < 100 && acc_n < (K - 1) * W + 4; cyc++) begin
      drive(1'b1, 1'b1, pat(r, c), fire, acc, ov, ir, col, wv, lst);
      if (acc) begin
        acc_n++;
        c++;
        if (c == W) begin c = 0; r++; end
      end
    end
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pending_beat: got %b expected 1", out_valid); end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0 || out_win_valid !== 1'b0) begin
      n_fail++; $display("FAIL mr_flags: got %b%b expected 00", out_win_valid, out_last);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_frame("after_reset");
  endtask

  task automatic test_random();
    logic [PW-1:0] img [H][W];
    beat_t q[$];
    beat_t b;
    int r = 0, c = 0, acc_n = 0, nbeats = 0;
    logic fire, acc, ov, ir, wv, lst, v, rdy;
    logic [PW-1:0] pix, px;
    logic [COLW-1:0] col;
    apply_reset();
    for (int cyc = 0; cyc < 3000 && acc_n < 3 * FRAME_PIX; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      pix = PW'($urandom);
      drive(v, rdy, pix, fire, acc, ov, ir, col, wv, lst);
      if (ov && !rdy) begin
        n_tests++;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL rnd_stall_in_ready: got %b expected 0", ir); end
      end
      if (fire) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious_beat: got column %h expected no beat", col);
        end else begin
          b = q.pop_front();
          if (col !== b.col || wv !== b.wv || lst !== b.lst) begin
            n_fail++;
            $display("FAIL rnd_beat%0d: got %h/%b/%b expected %h/%b/%b", nbeats, col, wv, lst, b.col, b.wv, b.lst);
          end
        end
        nbeats++;
      end
      if (acc) begin
        img[r][c] = pix;
        if (r >= K - 1) begin
          for (int k = 0; k < K; k++) begin
            px = img[r - (K - 1) + k][c];
            for (int ch = 0; ch < CH; ch++) b.col[(ch*K + k)*BW +: BW] = px[ch*BW +: BW];
          end
          b.wv  = (c >= K - 1);
          b.lst = (r == H - 1 && c == W - 1);
          q.push_back(b);
        end
        acc_n++;
        c++;
        if (c == W) begin c = 0; r = (r == H - 1) ? 0 : r + 1; end
      end
    end
    for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) begin
      drive(1'b0, 1'b1, '0, fire, acc, ov, ir, col, wv, lst);
      if (fire) begin
        n_tests++;
        b = q.pop_front();
        if (col !== b.col || wv !== b.wv || lst !== b.lst) begin
          n_fail++;
          $display("FAIL rnd_drain_beat: got %h/%b/%b expected %h/%b/%b", col, wv, lst, b.col, b.wv, b.lst);
        end
        nbeats++;
      end
    end
    n_tests += 3;
    if (acc_n != 3 * FRAME_PIX) begin n_fail++; $display("FAIL rnd_accepted: got %0d expected %0d", acc_n, 3 * FRAME_PIX); end
    if (q.size() != 0) begin n_fail++; $display("FAIL rnd_missing_beats: got %0d outstanding expected 0", q.size()); end
    if (nbeats != 3 * (H - K + 1) * W) begin n_fail++; $display("FAIL rnd_beat_count: got %0d expected %0d", nbeats, 3 * (H - K + 1) * W); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    @(negedge clk);
    test_reset();
    test_frame("frame1");
    test_frame("frame2");
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
